power_iter_normalize: RTL

//  Back end of one power-iteration pass in the eigen-decomposition path.
//  - Takes the product vector from the matrix-vector multiply and finds its largest-magnitude element.
//  - Rescales the vector by a power of two, using exponent arithmetic only, so that element lands in [1,2).
//  - Compares the result with the previous pass to flag convergence.
//  - Output feeds back as the multiply's next vector operand.

---
 rtl/power_iter_normalize_pkg.sv | 27 ++
 rtl/double_exp_rescale.sv | 36 +++
 rtl/power_iter_normalize.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/power_iter_normalize_pkg.sv
// Shared IEEE-754 binary64 field helpers and FSM state type for the power-iteration normaliser.
package power_iter_normalize_pkg;

  localparam int unsigned DBL_W        = 64;
  localparam int unsigned DBL_EXP_W    = 11;
  localparam int unsigned DBL_SIGN_BIT = 63;
  localparam int unsigned DBL_EXP_MSB  = 62;
  localparam int unsigned DBL_EXP_LSB  = 52;
  localparam int unsigned DBL_MANT_MSB = 51;

  localparam logic [DBL_EXP_W-1:0] DBL_EXP_BIAS = 11'd1023;
  localparam logic [DBL_EXP_W-1:0] DBL_EXP_INF  = 11'd2047;

  typedef logic [DBL_W-1:0] double_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_SCALE,
    ST_DONE
  } pin_state_e;

  function automatic logic [DBL_EXP_W-1:0] dbl_exp(input double_t x);
    return x[DBL_EXP_MSB:DBL_EXP_LSB];
  endfunction

endpackage

// File: rtl/double_exp_rescale.sv
// Rescales one double by 2^-(max_exp-bias) through exponent arithmetic and
// compares the result with the same element of the previous pass.
module double_exp_rescale
  import power_iter_normalize_pkg::*;
#(
  parameter int unsigned TOL_ULP = 16
) (
  input  double_t              x,
  input  logic [DBL_EXP_W-1:0] max_exp,
  input  logic                 force_zero,
  input  double_t              prev,
  input  logic                 prev_valid,
  output double_t              y,
  output logic                 ok
);

  logic [DBL_EXP_W-1:0] e;
  logic signed [12:0]   ne;
  logic [DBL_SIGN_BIT-1:0] diff;

  always_comb begin
    e    = dbl_exp(x);
    ne   = $signed(13'(e)) - $signed(13'(max_exp)) + $signed(13'(DBL_EXP_BIAS));
    y    = '0;
    // Zero/denormal inputs and results that fall below the normal range flush to +0
    if (!((e == '0) || (max_exp == '0) || force_zero || (ne <= 13'sd0))) begin
      y = {x[DBL_SIGN_BIT], ne[DBL_EXP_W-1:0], x[DBL_MANT_MSB:0]};
    end
    diff = (y[DBL_SIGN_BIT-1:0] >= prev[DBL_SIGN_BIT-1:0])
         ? (y[DBL_SIGN_BIT-1:0] - prev[DBL_SIGN_BIT-1:0])
         : (prev[DBL_SIGN_BIT-1:0] - y[DBL_SIGN_BIT-1:0]);
    ok   = prev_valid && (y[DBL_SIGN_BIT] == prev[DBL_SIGN_BIT])
        && (diff <= 63'(TOL_ULP));
  end

endmodule

// File: rtl/power_iter_normalize.sv
// Power-iteration back end: max-exponent scan, power-of-two rescale, convergence check.
// Optional pass limit enabled by defining ITER_LIMIT_EN.
module power_iter_normalize
  import power_iter_normalize_pkg::*;
#(
  parameter int unsigned SIZE_N   = 8,
  parameter int unsigned TOL_ULP  = 16,
  parameter int unsigned MAX_ITER = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          restart,
  input  logic [SIZE_N-1:0][DBL_W-1:0]  vector_in,
  output logic [SIZE_N-1:0][DBL_W-1:0]  vector_out,
  output logic signed [11:0]            shift_exp,
  output logic [15:0]                   iter_count,
  output logic                          converged,
  output logic                          zero_vec,
  output logic                          err,
  output logic                          limit_hit,
  output logic                          busy,
  output logic                          f
);

  localparam int unsigned IDX_W   = (SIZE_N > 1) ? $clog2(SIZE_N) : 1;
  localparam int unsigned SHIFT_W = 12;

`ifdef ITER_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  pin_state_e                     state;
  logic [SIZE_N-1:0][DBL_W-1:0]   in_reg;
  logic [SIZE_N-1:0][DBL_W-1:0]   scaled;
  logic [SIZE_N-1:0][DBL_W-1:0]   prev;
  logic                           prev_valid;
  logic [IDX_W-1:0]               idx;
  logic [DBL_EXP_W-1:0]           max_exp;
  logic                           err_acc;
  logic                           conv_acc;

  double_t                        cur_c;
  double_t                        y_c;
  logic                           ok_c;
  logic [DBL_EXP_W-1:0]           cur_exp_c;
  logic                           last_c;
  logic                           zero_c;
  logic                           conv_c;

  assign cur_c     = in_reg[idx];
  assign cur_exp_c = dbl_exp(cur_c);
  assign last_c    = (idx == IDX_W'(SIZE_N - 1));
  assign zero_c    = (max_exp == '0) && !err_acc;
  assign conv_c    = conv_acc && !zero_c && !err_acc;

  // Single rescaler time-shared across the SCALE sweep
  double_exp_rescale #(
    .TOL_ULP (TOL_ULP)
  ) u_rescale (
    .x          (cur_c),
    .max_exp    (max_exp),
    .force_zero (err_acc),
    .prev       (prev[idx]),
    .prev_valid (prev_valid),
    .y          (y_c),
    .ok         (ok_c)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      in_reg     <= '0;
      scaled     <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
      idx        <= '0;
      max_exp    <= '0;
      err_acc    <= 1'b0;
      conv_acc   <= 1'b0;
      vector_out <= '0;
      shift_exp  <= '0;
      iter_count <= '0;
      converged  <= 1'b0;
      zero_vec   <= 1'b0;
      err        <= 1'b0;
      limit_hit  <= 1'b0;
      busy       <= 1'b0;
      f          <= 1'b0;
    end else begin
      f <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (restart) begin
            prev_valid <= 1'b0;
            iter_count <= '0;
            limit_hit  <= 1'b0;
          end
          // restart takes effect first, so it also unblocks a same-cycle start
          if (start && (restart || !(LIMIT_EN && limit_hit))) begin
            in_reg   <= vector_in;
            idx      <= '0;
            max_exp  <= '0;
            err_acc  <= 1'b0;
            conv_acc <= 1'b1;
            busy     <= 1'b1;
            state    <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (cur_exp_c == DBL_EXP_INF) begin
            err_acc <= 1'b1;
          end else if (cur_exp_c > max_exp) begin
            max_exp <= cur_exp_c;
          end
          if (last_c) begin
            idx   <= '0;
            state <= ST_SCALE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_SCALE: begin
          scaled[idx] <= y_c;
          conv_acc    <= conv_acc & ok_c;
          if (last_c) begin
            idx   <= '0;
            state <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          vector_out <= scaled;
          prev       <= scaled;
          prev_valid <= 1'b1;
          shift_exp  <= zero_c ? '0
                      : ($signed(SHIFT_W'(max_exp)) - $signed(SHIFT_W'(DBL_EXP_BIAS)));
          zero_vec   <= zero_c;
          err        <= err_acc;
          converged  <= conv_c;
          if (iter_count != '1) begin
            iter_count <= iter_count + 1'b1;
          end
          if (LIMIT_EN && !conv_c && ((32'(iter_count) + 32'd1) >= MAX_ITER)) begin
            limit_hit <= 1'b1;
          end
          busy  <= 1'b0;
          f     <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
